// File: rtl/isa_types.sv
// rtl/isa_types.sv - shared ISA constants and types for the load/store path
// Contents: XLEN, RV32I load/store funct3 codes, lsu_state_t, mem_size_t,
//           funct3 legality and access-size helpers.
package isa_types;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (store) begin
      case (f3)
        FUNCT3_SB, FUNCT3_SH, FUNCT3_SW: ok = 1'b1;
        default:                         ok = 1'b0;
      endcase
    end else begin
      case (f3)
        FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU: ok = 1'b1;
        default:                                                 ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Signed and unsigned variants share a size; illegal codes fall to WORD
  // but are rejected by funct3_legal before they matter.
  function automatic mem_size_t funct3_size(input logic [2:0] f3);
    mem_size_t s;
    case (f3[1:0])
      2'b00:   s = BYTE;
      2'b01:   s = HALF;
      default: s = WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane alignment for word-addressed data memory
// Ports: offset_i  byte offset addr[1:0]
//        size_i    access size (mem_size_t encoding)
//        wdata_i   right-justified store data
//        rdata_i   memory word read data
//        be_o      byte enables
//        wdata_o   lane-shifted store data
//        rdata_o   right-justified, zero-filled load bytes
//        misaligned_o  access crosses its natural alignment
module lsu_lane_align
  import isa_types::*;
(
  input  logic [1:0]      offset_i,
  input  logic [1:0]      size_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misaligned_o
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] rd_sh;
  mem_size_t       size;

  assign shamt   = {offset_i, 3'b000};
  assign rd_sh   = rdata_i >> shamt;
  assign wdata_o = wdata_i << shamt;
  assign size    = mem_size_t'(size_i);

  always_comb begin
    be_o         = 4'b0000;
    rdata_o      = '0;
    misaligned_o = 1'b0;
    case (size)
      BYTE: begin
        be_o    = 4'b0001 << offset_i;
        rdata_o = {{(XLEN-8){1'b0}}, rd_sh[7:0]};
      end
      HALF: begin
        be_o         = 4'b0011 << offset_i;
        rdata_o      = {{(XLEN-16){1'b0}}, rd_sh[15:0]};
        misaligned_o = offset_i[0];
      end
      default: begin
        be_o         = 4'b1111;
        rdata_o      = rd_sh;
        misaligned_o = |offset_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit for the data memory
// Ports: clk, reset_n (sync, active-low)
//        req_*   execute-stage request (valid/ready, store, funct3, addr, wdata)
//        resp_*  one-cycle completion pulse with right-justified rdata and err
//        mem_*   request/grant/response handshake to word-addressed memory
module load_store_unit
  import isa_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  lsu_state_t      state_q;
  logic [1:0]      off_q;
  mem_size_t       size_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            timeout;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [3:0]      mem_be_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic            resp_err_q;

  logic [1:0]      al_off;
  mem_size_t       al_size;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_mis;
  logic            req_illegal;

  // The aligner sees the live request while IDLE (to classify and latch it)
  // and the latched offset/size afterwards (to extract read data).
  assign al_off      = (state_q == LSU_IDLE) ? req_addr[1:0] : off_q;
  assign al_size     = (state_q == LSU_IDLE) ? funct3_size(req_funct3) : size_q;
  assign req_illegal = !funct3_legal(req_store, req_funct3);

  lsu_lane_align u_align (
    .offset_i     (al_off),
    .size_i       (al_size),
    .wdata_i      (req_wdata),
    .rdata_i      (mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  assign cnt_d   = cnt_q + CNT_W'(1);
  assign timeout = (cnt_d >= CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= LSU_IDLE;
      off_q        <= 2'b00;
      size_q       <= BYTE;
      cnt_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (req_valid) begin
            off_q        <= req_addr[1:0];
            size_q       <= funct3_size(req_funct3);
            mem_we_q     <= req_store;
            mem_addr_q   <= {req_addr[XLEN-1:2], 2'b00};
            mem_be_q     <= al_be;
            mem_wdata_q  <= al_wdata;
            resp_rdata_q <= '0;
            cnt_q        <= '0;
            if (req_illegal || al_mis) begin
              resp_err_q <= 1'b1;
              state_q    <= LSU_DONE;
            end else begin
              resp_err_q <= 1'b0;
              state_q    <= LSU_REQ;
            end
          end
        end
        // A grant or response on the expiry cycle still wins: once memory has
        // taken the request, abandoning it would orphan the transaction.
        LSU_REQ: begin
          cnt_q <= cnt_d;
          if (mem_gnt) begin
            state_q <= LSU_WAIT;
          end else if (timeout) begin
            resp_err_q <= 1'b1;
            state_q    <= LSU_DONE;
          end
        end
        LSU_WAIT: begin
          cnt_q <= cnt_d;
          if (mem_rvalid) begin
            resp_rdata_q <= mem_we_q ? '0 : al_rdata;
            state_q      <= LSU_DONE;
          end else if (timeout) begin
            resp_err_q <= 1'b1;
            state_q    <= LSU_DONE;
          end
        end
        default: begin
          state_q <= LSU_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == LSU_IDLE);
  assign mem_req    = (state_q == LSU_REQ);
  assign resp_valid = (state_q == LSU_DONE);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every resp_valid pulse must match the oldest expectation,
  // including the edge at which it is sampled.
  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
        chk("resp_edge", cyc + 1, mon_e.at_edge);
      end
    end
  end

  // Called at a negedge while IDLE; returns at the negedge after acceptance.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic push, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat);
    exp_t e;
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    if (push) begin
      e.rdata   = exp_rd;
      e.err     = exp_err;
      e.at_edge = cyc + 1 + lat;
      sb.push_back(e);
    end
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic mem_access(input int gnt_delay, input logic [31:0] rd,
                            input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wdata, input logic e_we);
    for (int i = 0; i <= gnt_delay; i++) begin
      chk("mem_req_held", {31'b0, mem_req}, 32'd1);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_be", {28'b0, mem_be}, {28'b0, e_be});
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      mem_gnt = (i == gnt_delay);
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    chk("mem_req_dropped", {31'b0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic err_case(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    issue(st, f3, addr, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1);
    chk("err_no_mem_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // SW, zero-wait memory
    issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 3);
    mem_access(0, 32'h0, 32'h104, 4'b1111, 32'hDEADBEEF, 1'b1);

    // SB to the top byte lane
    issue(1'b1, 3'b000, 32'h203, 32'h000000A5, 1'b1, 32'h0, 1'b0, 3);
    mem_access(0, 32'h0, 32'h200, 4'b1000, 32'hA5000000, 1'b1);

    // SH to the upper half
    issue(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 1'b1, 32'h0, 1'b0, 3);
    mem_access(0, 32'h0, 32'h100, 4'b1100, 32'hBEEF0000, 1'b1);

    // LHU with grant delayed 3 cycles
    issue(1'b0, 3'b101, 32'h102, 32'h00001234, 1'b1, 32'h00008001, 1'b0, 6);
    mem_access(3, 32'h8001FFFF, 32'h100, 4'b1100, 32'h12340000, 1'b0);

    // LB from lane 1
    issue(1'b0, 3'b000, 32'h001, 32'h0, 1'b1, 32'h000000AB, 1'b0, 3);
    mem_access(0, 32'h0000AB00, 32'h000, 4'b0010, 32'h0, 1'b0);

    // Error requests
    err_case(1'b0, 3'b010, 32'h101);
    err_case(1'b0, 3'b011, 32'h100);
    err_case(1'b0, 3'b001, 32'h103);
    err_case(1'b1, 3'b100, 32'h100);

    // Grant and rvalid together in REQ: only the later rvalid counts.
    // req_valid held during REQ/WAIT must not start a second access.
    issue(1'b0, 3'b010, 32'h020, 32'h0, 1'b1, 32'h12345678, 1'b0, 3);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAAAAAA;
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h033;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("dual_mem_req", {31'b0, mem_req}, 32'd0);
    chk("dual_mem_addr", mem_addr, 32'h020);
    chk("dual_mem_we", {31'b0, mem_we}, 32'd0);
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    req_valid  = 1'b0;
    @(negedge clk);

    // Timeout: grant given, rvalid never comes
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1, 5);
    chk("to_mem_req", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("to_mem_req_drop", {31'b0, mem_req}, 32'd0);
    repeat (4) @(negedge clk);
    chk("to_back_idle", {31'b0, req_ready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);

    // Reset during WAIT aborts the access without a response
    issue(1'b0, 3'b010, 32'h040, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    issue(1'b0, 3'b000, 32'h003, 32'h0, 1'b1, 32'h0000007F, 1'b0, 3);
    mem_access(0, 32'h7F000000, 32'h000, 4'b1000, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
